wb_arbiter: RTL

//  Writeback arbiter sitting directly upstream of the register-file write port
//  (we3/rd/wd3). Merges two result sources into the single write port:
//  - the in-order pipeline writeback, which never stalls;
//  - a long-latency secondary source (mul/div, slow load), which is buffered in a small FIFO.

---
 rtl/rv_pkg.sv | 11 +
 rtl/wb_arbiter_if.sv | 29 ++
 rtl/wb_fifo.sv | 72 +++++++
 rtl/wb_arbiter.sv | 91 +++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared core constants and the writeback entry type.
package rv_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline and secondary sources in, register-file port out.
interface wb_arbiter_if import rv_pkg::*; #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   pipe_we;
  logic [REG_AW-1:0]      pipe_rd;
  logic [XLEN-1:0]        pipe_wd;
  logic                   sec_valid;
  logic                   sec_ready;
  logic [REG_AW-1:0]      sec_rd;
  logic [XLEN-1:0]        sec_wd;
  logic                   we3;
  logic [REG_AW-1:0]      rd;
  logic [XLEN-1:0]        wd3;
  logic [2**REG_AW-1:0]   pending_mask;
  logic [CW-1:0]          fifo_count;

  modport master (
    output pipe_we, pipe_rd, pipe_wd, sec_valid, sec_rd, sec_wd,
    input  sec_ready, we3, rd, wd3, pending_mask, fifo_count
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_wd, sec_valid, sec_rd, sec_wd,
    output sec_ready, we3, rd, wd3, pending_mask, fifo_count
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of writeback entries with squash-by-destination.
// Squashed entries keep their slot; a popped slot has its valid cleared so
// unoccupied slots never contribute to the pending mask.
module wb_fifo import rv_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  wb_entry_t               push_ent_i,
  input  logic                    pop_i,
  input  logic                    squash_i,
  input  logic [REG_AW-1:0]       squash_rd_i,
  output wb_entry_t               head_o,
  output logic [CW-1:0]           count_o,
  output logic [DEPTH-1:0]        vld_o,
  output wb_entry_t [DEPTH-1:0]   ent_o
);
  wb_entry_t [DEPTH-1:0] ents_q, ents_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Next state: squash on start-of-cycle contents, then pop clear, then push.
  always_comb begin
    ents_d = ents_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (squash_i && ents_q[i].rd == squash_rd_i) ents_d[i].valid = 1'b0;
    end
    if (pop_i) begin
      ents_d[head_q].valid = 1'b0;
      head_d = head_q + PW'(1);
    end
    if (push_i) begin
      ents_d[tail_q] = push_ent_i;
      tail_d = tail_q + PW'(1);
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State register; reset empties the buffer and clears all valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      ents_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      ents_q <= ents_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Expose per-slot valids and contents for the pending-mask reduction.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) vld_o[i] = ents_q[i].valid;
  end

  assign ent_o   = ents_q;
  assign head_o  = ents_q[head_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline has priority, secondary results wait in a FIFO.
// Pipeline writes squash older buffered writes to the same register (WAW).
module wb_arbiter import rv_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                    pipe_req, acc, push, pop;
  wb_entry_t               head, push_ent;
  logic [CW-1:0]           count;
  logic [DEPTH-1:0]        vld;
  wb_entry_t [DEPTH-1:0]   ents;
  logic                    we3_q, we3_d;
  logic [REG_AW-1:0]       rd_q, rd_d;
  logic [XLEN-1:0]         wd3_q, wd3_d;
  logic [2**REG_AW-1:0]    pmask;

  // Handshake and FIFO control; a same-cycle secondary to the pipe's rd is older, so dropped.
  always_comb begin
    pipe_req       = bus.pipe_we && (bus.pipe_rd != '0);
    bus.sec_ready  = !rst && (count < CW'(DEPTH));
    acc            = bus.sec_valid && bus.sec_ready;
    push           = acc && (bus.sec_rd != '0) && !(pipe_req && bus.sec_rd == bus.pipe_rd);
    pop            = !pipe_req && (count != '0);
    push_ent.valid = 1'b1;
    push_ent.rd    = bus.sec_rd;
    push_ent.wd    = bus.sec_wd;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_ent_i  (push_ent),
    .pop_i       (pop),
    .squash_i    (pipe_req),
    .squash_rd_i (bus.pipe_rd),
    .head_o      (head),
    .count_o     (count),
    .vld_o       (vld),
    .ent_o       (ents)
  );

  // Port select: pipe first, then FIFO head; a squashed head burns a cycle with no write.
  always_comb begin
    we3_d = 1'b0;
    rd_d  = rd_q;
    wd3_d = wd3_q;
    if (pipe_req) begin
      we3_d = 1'b1;
      rd_d  = bus.pipe_rd;
      wd3_d = bus.pipe_wd;
    end else if (pop && head.valid) begin
      we3_d = 1'b1;
      rd_d  = head.rd;
      wd3_d = head.wd;
    end
  end

  // Register-file port registers, stable across the negedge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      we3_q <= 1'b0;
      rd_q  <= '0;
      wd3_q <= '0;
    end else begin
      we3_q <= we3_d;
      rd_q  <= rd_d;
      wd3_q <= wd3_d;
    end
  end

  // Pending mask: OR of one-hot destinations of live buffered entries.
  always_comb begin
    pmask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i]) pmask[ents[i].rd] = 1'b1;
    end
    pmask[0] = 1'b0;
  end

  assign bus.we3          = we3_q;
  assign bus.rd           = rd_q;
  assign bus.wd3          = wd3_q;
  assign bus.pending_mask = pmask;
  assign bus.fifo_count   = count;
endmodule
